// File: rtl/key_debounce.sv
// key_debounce: synchronises active-low push-button pins to sys_clk and
// debounces each key independently. Produces clean active-low levels,
// one-cycle press/release strobes, an any-key flag and a priority-encoded
// key code (lowest pressed index wins).
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         key_in,
  output logic [N_KEYS-1:0]         key_out,
  output logic [N_KEYS-1:0]         key_press,
  output logic [N_KEYS-1:0]         key_release,
  output logic                      key_any,
  output logic [$clog2(N_KEYS)-1:0] key_code
);

  localparam int KC_W = $clog2(N_KEYS);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    REL    = 2'd0,
    WAIT_P = 2'd1,
    PRS    = 2'd2,
    WAIT_R = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  // Per-key "debounce accepted" flags; a set bit means the level flips on this edge.
  logic [N_KEYS-1:0] acc_press;
  logic [N_KEYS-1:0] acc_release;

  logic [N_KEYS-1:0] key_out_q;
  logic [N_KEYS-1:0] key_out_d;
  logic [N_KEYS-1:0] key_press_q;
  logic [N_KEYS-1:0] key_release_q;
  logic              key_any_q;
  logic              key_any_d;
  logic [KC_W-1:0]   key_code_q;
  logic [KC_W-1:0]   key_code_d;

  // Two-flop synchroniser for the asynchronous key pins; idles released (1).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // The terminal compare is shared by the FSM and the output/strobe registers.
    assign acc_press[i]   = (state_q == WAIT_P) && !sync2_q[i] && (cnt_q == CNT_TERM);
    assign acc_release[i] = (state_q == WAIT_R) &&  sync2_q[i] && (cnt_q == CNT_TERM);

    // Per-key debounce FSM: any opposite-level sample restarts the attempt.
    always_ff @(posedge sys_clk) begin
      if (rst) begin
        state_q <= REL;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          REL: begin
            if (!sync2_q[i]) begin
              state_q <= WAIT_P;
              cnt_q   <= CNT_ONE;
            end
          end
          WAIT_P: begin
            if (sync2_q[i]) begin
              state_q <= REL;
              cnt_q   <= '0;
            end else if (acc_press[i]) begin
              state_q <= PRS;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PRS: begin
            if (sync2_q[i]) begin
              state_q <= WAIT_R;
              cnt_q   <= CNT_ONE;
            end
          end
          WAIT_R: begin
            if (!sync2_q[i]) begin
              state_q <= PRS;
              cnt_q   <= '0;
            end else if (acc_release[i]) begin
              state_q <= REL;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= REL;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Next debounced level plus the any/code summaries derived from it, so all
  // of them update on the same edge.
  always_comb begin
    key_out_d  = (key_out_q & ~acc_press) | acc_release;
    key_any_d  = ~&key_out_d;
    key_code_d = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (!key_out_d[k]) key_code_d = KC_W'(k);
    end
  end

  // Registered outputs; strobes are high only on the edge the level flips.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      key_out_q     <= '1;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_any_q     <= 1'b0;
      key_code_q    <= '0;
    end else begin
      key_out_q     <= key_out_d;
      key_press_q   <= acc_press;
      key_release_q <= acc_release;
      key_any_q     <= key_any_d;
      key_code_q    <= key_code_d;
    end
  end

  assign key_out     = key_out_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_any     = key_any_q;
  assign key_code    = key_code_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios followed by randomized key
// bouncing and occasional resets, all checked against a sample-window model.
module tb_key_debounce;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_out;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         key_any;
  logic [1:0]   key_code;

  key_debounce #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_out     (key_out),
    .key_press   (key_press),
    .key_release (key_release),
    .key_any     (key_any),
    .key_code    (key_code)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: synchroniser image, debounced level and the
  // last DC synchronised samples per key.
  logic [N-1:0]  m_s1, m_s2, m_lvl;
  logic [DC-1:0] hist [N];
  logic [N-1:0]  e_press, e_rel;
  logic          e_any;
  logic [1:0]    e_code;
  int            npress [N];
  int            nrel    [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One model step for the edge just passed, using the inputs it sampled.
  // A level flips once the last DC synchronised samples all oppose it.
  task automatic model_step();
    logic [N-1:0] nl;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '1;
      for (int k = 0; k < N; k++) hist[k] = '1;
      e_press = '0; e_rel = '0; e_any = 1'b0; e_code = '0;
    end else begin
      nl = m_lvl;
      for (int k = 0; k < N; k++) begin
        hist[k] = {hist[k][DC-2:0], m_s2[k]};
        if (hist[k] == {DC{~m_lvl[k]}}) nl[k] = ~m_lvl[k];
      end
      e_press = m_lvl & ~nl;
      e_rel   = ~m_lvl & nl;
      m_lvl   = nl;
      e_any   = (nl != '1);
      e_code  = '0;
      for (int k = N - 1; k >= 0; k--) if (!nl[k]) e_code = 2'(k);
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    model_step();
    chk("key_out",     32'(key_out),     32'(m_lvl));
    chk("key_press",   32'(key_press),   32'(e_press));
    chk("key_release", 32'(key_release), 32'(e_rel));
    chk("key_any",     32'(key_any),     32'(e_any));
    chk("key_code",    32'(key_code),    32'(e_code));
    for (int k = 0; k < N; k++) begin
      npress[k] += int'(key_press[k]);
      nrel[k]   += int'(key_release[k]);
    end
  endtask

  int p0, r0;

  initial begin
    for (int k = 0; k < N; k++) begin npress[k] = 0; nrel[k] = 0; end

    // Reset with all keys held low.
    rst = 1'b1; key_in = '0;
    repeat (3) tick();
    chk("rst_out", 32'(key_out), 32'hF);
    rst = 1'b0; key_in = '1;
    tick();
    chk("post_rst_out",  32'(key_out),   32'hF);
    chk("post_rst_any",  32'(key_any),   32'h0);
    chk("post_rst_prs",  32'(key_press), 32'h0);
    repeat (4) tick();

    // Clean press and release of key 0.
    key_in[0] = 1'b0;
    repeat (5) tick();
    chk("p0_before_E5", 32'(key_out), 32'hF);
    tick();
    chk("p0_out_E5",   32'(key_out),   32'hE);
    chk("p0_press_E5", 32'(key_press), 32'h1);
    chk("p0_any_E5",   32'(key_any),   32'h1);
    tick();
    chk("p0_press_1cyc", 32'(key_press), 32'h0);
    repeat (4) tick();
    key_in[0] = 1'b1;
    repeat (6) tick();
    chk("r0_out",     32'(key_out),     32'hF);
    chk("r0_release", 32'(key_release), 32'h1);
    tick();
    chk("r0_rel_1cyc", 32'(key_release), 32'h0);
    repeat (3) tick();

    // Bouncing press of key 1.
    p0 = npress[1];
    begin
      logic [9:0] seq;
      seq = 10'b0100100000;
      for (int j = 9; j >= 0; j--) begin
        key_in[1] = seq[j];
        tick();
      end
    end
    repeat (8) tick();
    chk("bounce_presses", 32'(npress[1] - p0), 32'd1);
    chk("bounce_out",     32'(key_out),        32'hD);
    key_in[1] = 1'b1;
    repeat (8) tick();

    // Short glitch on key 2.
    p0 = npress[2]; r0 = nrel[2];
    key_in[2] = 1'b0;
    repeat (3) tick();
    key_in[2] = 1'b1;
    repeat (8) tick();
    chk("glitch_press", 32'(npress[2] - p0), 32'd0);
    chk("glitch_rel",   32'(nrel[2] - r0),   32'd0);
    chk("glitch_out",   32'(key_out),        32'hF);

    // Simultaneous press of keys 0 and 2, then release of key 0 only.
    key_in = 4'b1010;
    repeat (6) tick();
    chk("sim_out",   32'(key_out),   32'hA);
    chk("sim_press", 32'(key_press), 32'h5);
    chk("sim_code",  32'(key_code),  32'h0);
    repeat (3) tick();
    key_in[0] = 1'b1;
    repeat (6) tick();
    chk("sim_rel_out",  32'(key_out),  32'hB);
    chk("sim_rel_code", 32'(key_code), 32'h2);
    key_in = '1;
    repeat (8) tick();

    // Reset in the middle of a key 3 count.
    p0 = npress[3];
    key_in[3] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_mid_no_press", 32'(npress[3] - p0), 32'd0);
    tick();
    chk("rst_mid_press", 32'(key_press), 32'h8);
    key_in[3] = 1'b1;
    repeat (8) tick();

    // Randomized bouncing on all keys with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(5) == 0) key_in[k] = ~key_in[k];
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
